// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the APB initiator.
//               - apb_state_t : transfer FSM states (IDLE, SETUP, ACCESS)
//               - PWM_*_OFS   : register offsets of the PWM responder
//               - APB_TIMEOUT_CYC_DEF : default ACCESS-cycle timeout
//               - is_word_aligned()   : byte-address alignment helper
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // PWM responder register map (byte offsets)
    localparam logic [7:0] PWM_PERIOD_OFS = 8'h00;
    localparam logic [7:0] PWM_PULSE_OFS  = 8'h04;
    localparam logic [7:0] PWM_SIZE_OFS   = 8'h08;
    localparam logic [7:0] PWM_ENABLE_OFS = 8'h0C;

    localparam int unsigned APB_TIMEOUT_CYC_DEF = 16;

    // Transfers are whole 32-bit words; any nonzero byte lane offset is rejected.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_wdog.sv
// ============================================================================
// Module      : apb_wdog
// Description : ACCESS-phase watchdog. Counts ACCESS cycles of the current
//               transfer and flags the last allowed cycle so the initiator
//               can abort if PREADY is still low there.
// Ports       : clk_i      - clock, rising edge
//               rst_ni     - asynchronous active-low reset
//               clr_i      - clear counter (transfer is in SETUP)
//               cnt_en_i   - count this cycle (transfer is in ACCESS)
//               expire_o   - current ACCESS cycle is the TIMEOUT_CYC-th one
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wdog #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of ACCESS cycles already completed, so the
    // final allowed cycle is the one where TIMEOUT_CYC-1 have gone by.
    assign expire_o = cnt_en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/apb_master.sv
// ============================================================================
// Module      : apb_master
// Description : APB initiator. Converts a valid/ready command into a single
//               APB transfer (SETUP, then ACCESS with PREADY wait states) and
//               returns read data / error on a held valid/ready response.
//               Misaligned commands are answered with an error and never
//               reach the bus.
// Config      : APB_TIMEOUT_EN - when defined, an ACCESS phase lasting
//               TIMEOUT_CYC cycles without PREADY is aborted with an error.
// Ports       : PCLK, PRESETn                    - clock / async low reset
//               cmd_valid/ready/write/addr/wdata - command channel
//               rsp_valid/ready/rdata/err        - response channel
//               PADDR/PSEL/PENABLE/PWRITE/PWDATA - APB request (registered)
//               PREADY/PRDATA/PSLAVEERR          - APB completion
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLAVEERR
);

    apb_state_t        state_q,     state_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic              access_expired;

`ifdef APB_TIMEOUT_EN
    apb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk_i    (PCLK),
        .rst_ni   (PRESETn),
        .clr_i    (state_q == SETUP),
        .cnt_en_i (state_q == ACCESS),
        .expire_o (access_expired)
    );
`else
    assign access_expired = 1'b0;
`endif

    // Gated with PRESETn so no command can be accepted while reset is held.
    assign cmd_ready = PRESETn && (state_q == IDLE) && !rsp_valid_q;

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        // Only valid drops on consumption; data and error stay visible.
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    if (!is_word_aligned(cmd_addr[1:0])) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                    end
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end

            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLAVEERR;
                    rsp_rdata_d = (!pwrite_q && !PSLAVEERR) ? PRDATA : '0;
                end else if (access_expired) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end

            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PADDR     = paddr_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
// ============================================================================
// Module      : tb_apb_master
// Description : Self-checking bench for apb_master. A memory-backed APB stub
//               with programmable wait states answers the bus; a word-array
//               reference model predicts every response and its cycle timing.
// Config      : APB_TIMEOUT_EN - adds the ACCESS timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master;

    localparam int unsigned TCYC = 4;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLAVEERR;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLAVEERR (PSLAVEERR)
    );

    // ---------------- APB responder stub ----------------
    logic [31:0] smem [16];
    int          stub_waits = 0;
    int          wcnt;

    assign PREADY    = (wcnt >= stub_waits);
    assign PSLAVEERR = (PADDR == 32'h10);
    // Deliberately nonzero on writes/errors so the initiator must mask it.
    assign PRDATA    = smem[PADDR[5:2]] ^ (PSLAVEERR ? 32'hBAD0_0000 : 32'h0);

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wcnt <= 0;
        end else if (PSEL && PENABLE && !PREADY) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    always @(posedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && PREADY && PWRITE && !PSLAVEERR)
            smem[PADDR[5:2]] <= PWDATA;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge. Issues one command, follows its bus
    // phases cycle by cycle, holds the response for 'hold' cycles with a
    // competing command pending, then consumes it.
    task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input int hold);
        bit          mis, to, exp_err;
        logic [31:0] exp_rd;
        int          n_acc;

        mis = (a[1:0] != 2'b00);
        to  = TO_EN && (waits >= int'(TCYC));
        if (mis || to || (a == 32'h10)) begin
            exp_err = 1'b1;
            exp_rd  = 32'h0;
        end else if (wr) begin
            exp_err = 1'b0;
            exp_rd  = 32'h0;
            ref_mem[a[5:2]] = wd;
        end else begin
            exp_err = 1'b0;
            exp_rd  = ref_mem[a[5:2]];
        end
        n_acc = to ? int'(TCYC) : waits + 1;

        stub_waits = waits;
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_addr   = a;
        cmd_wdata  = wd;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge PCLK);                          // accept edge N
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = ~wr;
        if (mis) begin
            chk("mis_psel", PSEL, 0);
            chk("mis_rsp_valid", rsp_valid, 1);
        end else begin
            chk("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
            chk("setup_paddr", PADDR, a);
            chk("setup_pwrite", PWRITE, wr);
            chk("setup_pwdata", PWDATA, wr ? wd : 32'h0);
            for (int i = 0; i < n_acc; i++) begin
                @(negedge PCLK);
                chk("access_psel_penable", {PSEL, PENABLE}, 2'b11);
                chk("access_paddr_stable", {PADDR, PWDATA}, {a, wr ? wd : 32'h0});
                chk("access_no_rsp", rsp_valid, 0);
            end
            @(negedge PCLK);                      // response edge N+1+n_acc
            chk("done_psel_penable", {PSEL, PENABLE}, 2'b00);
            chk("done_rsp_valid", rsp_valid, 1);
        end
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);

        rsp_ready = 1'b0;
        cmd_valid = 1'b1;                         // competing command must stall
        cmd_addr  = 32'h8;
        for (int i = 0; i < hold; i++) begin
            chk("bp_cmd_ready", cmd_ready, 0);
            @(negedge PCLK);
            chk("bp_held", {rsp_valid, rsp_err, rsp_rdata, PSEL}, {1'b1, exp_err, exp_rd, 1'b0});
        end
        chk("pre_consume_cmd_ready", cmd_ready, 0);
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("consume_rsp_valid", rsp_valid, 0);
        chk("consume_keep", {rsp_err, rsp_rdata}, {exp_err, exp_rd});
        chk("consume_cmd_ready", cmd_ready, 1);
        chk("consume_psel", PSEL, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            smem[i]    = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge PCLK);
        cmd_valid = 1'b1;
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 67'h0);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PRESETn   = 1'b1;
        @(negedge PCLK);

        // Directed: PWM-style write/read, wait states, slave error, misaligned
        do_cmd(1'b1, 32'h0,  32'd8,          0, 0);
        do_cmd(1'b0, 32'h0,  32'h0,          0, 0);
        do_cmd(1'b1, 32'h4,  32'd2,          0, 0);
        do_cmd(1'b0, 32'h4,  32'h0,          3, 0);
        do_cmd(1'b1, 32'h10, 32'h1234_5678,  0, 0);
        do_cmd(1'b0, 32'h10, 32'h0,          1, 0);
        do_cmd(1'b1, 32'h6,  32'hFFFF_FFFF,  0, 0);
        do_cmd(1'b0, 32'h0,  32'h0,          0, 5);   // backpressure, 5 cycles

        // Randomized commands; waits up to TCYC-1 keep within any timeout
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 4) == 0) ra = ra | $urandom_range(1, 3);
            do_cmd(1'($urandom_range(0, 1)), ra, $urandom,
                   $urandom_range(0, TCYC - 1), $urandom_range(0, 2));
        end

`ifdef APB_TIMEOUT_EN
        do_cmd(1'b0, 32'hC, 32'h0, 100, 1);           // stuck PREADY
        do_cmd(1'b1, 32'hC, 32'h55, 100, 0);          // aborted write leaves memory alone
        do_cmd(1'b0, 32'hC, 32'h0, 0, 0);
`endif

        // Reset pulsed in the middle of ACCESS
        stub_waits = 50;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b0;
        cmd_addr   = 32'h8;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        chk("midrst_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 67'h0);
        chk("midrst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        @(negedge PCLK);
        PRESETn    = 1'b1;
        stub_waits = 0;
        rsp_ready  = 1'b1;
        repeat (4) begin
            @(negedge PCLK);
            chk("postrst_no_rsp", {rsp_valid, PSEL}, 2'b00);
        end
        rsp_ready = 1'b0;
        do_cmd(1'b0, 32'h8, 32'h0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
